// File: rtl/renorm_ctrl_if.sv
// -----------------------------------------------------------------------------
// renorm_ctrl_if
//
// Groups the two streaming channels of the renormalization controller:
//   symbol channel : in_valid, in_ready, in_range, in_low
//                    (stage 2 -> controller)
//   word channel   : word_valid, word_ready, word_data
//                    (controller -> precarry word sink)
//
// Modports:
//   master : the encoder pipeline side (drives symbols, consumes words)
//   slave  : the renormalization controller (consumes symbols, drives words)
// -----------------------------------------------------------------------------
interface renorm_ctrl_if #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24,
    parameter int WORD_WIDTH  = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [RANGE_WIDTH-1:0] in_range;
    logic [LOW_WIDTH-1:0]   in_low;

    logic                   word_valid;
    logic                   word_ready;
    logic [WORD_WIDTH-1:0]  word_data;

    modport master (
        output in_valid, in_range, in_low, word_ready,
        input  in_ready, word_valid, word_data
    );

    modport slave (
        input  in_valid, in_range, in_low, word_ready,
        output in_ready, word_valid, word_data
    );
endinterface

// File: rtl/renorm_ctrl.sv
// -----------------------------------------------------------------------------
// renorm_ctrl
//
// Sequential renormalization controller for the AV1 arithmetic encoder.
// Owns the encoder state (range, low, signed bit counter cnt), normalizes each
// symbol result by the leading-zero count of its range, extracts up to two
// completed precarry words per symbol into a 2-entry output buffer, and
// sequences the end-of-stream flush.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   bus (slave)     symbol channel in, precarry word channel out
//   flush_req       level request; flush starts when idle and no symbol offered
//   range_q/low_q   normalized range/low fed back to stages 1/2
//   cnt_q           signed bit counter
//   flush_done      one-cycle pulse after the last flush word is accepted
//   err_zero_range  sticky flag: a symbol with in_range==0 was accepted
//
// Optional feature (macro RENORM_STATS_EN): adds stat_symbols / stat_words,
// wrapping 32-bit counters of accepted symbols and popped words.
// -----------------------------------------------------------------------------
module renorm_ctrl #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24,
    parameter int D_SIZE      = 5,
    parameter int WORD_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    renorm_ctrl_if.slave           bus,
    input  logic                   flush_req,
    output logic [RANGE_WIDTH-1:0] range_q,
    output logic [LOW_WIDTH-1:0]   low_q,
    output logic signed [5:0]      cnt_q,
    output logic                   flush_done,
    output logic                   err_zero_range
`ifdef RENORM_STATS_EN
    ,
    output logic [31:0]            stat_symbols,
    output logic [31:0]            stat_words
`endif
);

    // Internal shift datapath is wide enough that low << d never overflows.
    localparam int SW = LOW_WIDTH + 16;

    typedef enum logic [1:0] {IDLE, EMIT, FLUSH, DONE} state_t;

    state_t state, state_next;

    logic [WORD_WIDTH-1:0] buf0, buf1;
    logic [1:0]            buf_count;

    logic accept, flush_start, pop;

    // Accept datapath
    logic [D_SIZE-1:0]      acc_d;
    logic signed [7:0]      d_ext, cnt_ext, acc_s, acc_c;
    logic [SW-1:0]          acc_lw;
    logic [D_SIZE-1:0]      acc_sh;
    logic [WORD_WIDTH-1:0]  acc_w0, acc_w1, acc_wt;
    logic [1:0]             acc_n;
    logic signed [5:0]      acc_cnt;
    logic [LOW_WIDTH-1:0]   acc_low;
    logic [RANGE_WIDTH-1:0] acc_range;

    // Flush datapath
    logic [SW-1:0]          fl_e;
    logic signed [7:0]      fl_s, fl_c;
    logic [D_SIZE-1:0]      fl_sh;
    logic [WORD_WIDTH-1:0]  fl_w0, fl_w1, fl_wt;
    logic [1:0]             fl_n;

    // Leading zeros of a range; zero is treated as 15 so the shift stays legal.
    function automatic logic [D_SIZE-1:0] lead_zeros(input logic [RANGE_WIDTH-1:0] r);
        logic [D_SIZE-1:0] n;
        n = D_SIZE'(RANGE_WIDTH - 1);
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (r[i]) n = D_SIZE'(RANGE_WIDTH - 1 - i);
        end
        return n;
    endfunction

    function automatic logic [SW-1:0] low_mask(input logic [D_SIZE-1:0] sh);
        return (SW'(1) << sh) - SW'(1);
    endfunction

    assign cnt_ext = 8'(cnt_q);

    always_comb begin : accept_path
        // NOTE: blocking assignments are deliberate here: acc_lw and acc_c are
        // updated step by step and each step must see the previous result.
        acc_d   = lead_zeros(bus.in_range);
        d_ext   = 8'(acc_d);
        acc_s   = cnt_ext + d_ext;
        acc_lw  = SW'(bus.in_low);
        acc_c   = cnt_ext + 8'sd16;
        acc_sh  = '0;
        acc_w0  = '0;
        acc_w1  = '0;
        acc_wt  = '0;
        acc_n   = 2'd0;
        acc_cnt = 6'(acc_s);
        if (acc_s >= 8'sd0) begin
            if (acc_s >= 8'sd8) begin
                acc_sh = acc_c[D_SIZE-1:0];
                acc_w0 = WORD_WIDTH'(acc_lw >> acc_sh);
                acc_lw = acc_lw & low_mask(acc_sh);
                acc_c  = acc_c - 8'sd8;
                acc_n  = 2'd1;
            end
            acc_sh = acc_c[D_SIZE-1:0];
            acc_wt = WORD_WIDTH'(acc_lw >> acc_sh);
            acc_lw = acc_lw & low_mask(acc_sh);
            if (acc_n == 2'd0) acc_w0 = acc_wt;
            else               acc_w1 = acc_wt;
            acc_n   = acc_n + 2'd1;
            acc_cnt = 6'(acc_c + d_ext - 8'sd24);
        end
        acc_low   = LOW_WIDTH'(acc_lw << acc_d);
        acc_range = bus.in_range << acc_d;
    end

    always_comb begin : flush_path
        // Round low up to a 2^14 boundary and set the terminating bit.
        fl_e  = ((SW'(low_q) + SW'(16'h3FFF)) & ~SW'(16'h3FFF)) | SW'(16'h4000);
        fl_s  = cnt_ext + 8'sd10;
        fl_c  = cnt_ext;
        fl_sh = '0;
        fl_w0 = '0;
        fl_w1 = '0;
        fl_wt = '0;
        fl_n  = 2'd0;
        for (int k = 0; k < 2; k++) begin
            if (fl_s > 8'sd0) begin
                fl_sh = D_SIZE'(fl_c + 8'sd16);
                fl_wt = WORD_WIDTH'(fl_e >> fl_sh);
                fl_e  = fl_e & low_mask(fl_sh);
                if (fl_n == 2'd0) fl_w0 = fl_wt;
                else              fl_w1 = fl_wt;
                fl_n = fl_n + 2'd1;
                fl_s = fl_s - 8'sd8;
                fl_c = fl_c - 8'sd8;
            end
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.word_valid = (buf_count != 2'd0);
    assign bus.word_data  = buf0;
    assign flush_done     = (state == DONE);

    // A symbol offered in IDLE always wins over a pending flush request.
    assign accept      = bus.in_valid && (state == IDLE);
    assign flush_start = !bus.in_valid && flush_req && (state == IDLE);
    assign pop         = bus.word_valid && bus.word_ready;

    always_comb begin : next_state
        // NOTE: default first so every path assigns state_next and no latch forms.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept && acc_n != 2'd0) state_next = EMIT;
                else if (flush_start)        state_next = (fl_n != 2'd0) ? FLUSH : DONE;
            end
            EMIT:    if (pop && buf_count == 2'd1) state_next = IDLE;
            FLUSH:   if (pop && buf_count == 2'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : state_reg
        // NOTE: non-blocking assignments for all clocked state so every register
        // samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin : datapath_reg
        if (reset) begin
            range_q        <= RANGE_WIDTH'(16'h8000);
            low_q          <= '0;
            cnt_q          <= -6'sd9;
            buf0           <= '0;
            buf1           <= '0;
            buf_count      <= 2'd0;
            err_zero_range <= 1'b0;
        end else begin
            if (accept) begin
                range_q   <= acc_range;
                low_q     <= acc_low;
                cnt_q     <= acc_cnt;
                buf0      <= acc_w0;
                buf1      <= acc_w1;
                buf_count <= acc_n;
                if (bus.in_range == '0) err_zero_range <= 1'b1;
            end else if (flush_start) begin
                buf0      <= fl_w0;
                buf1      <= fl_w1;
                buf_count <= fl_n;
            end else if (pop) begin
                buf0      <= buf1;
                buf_count <= buf_count - 2'd1;
            end
            // Flush complete: coder state returns to its initial values.
            if (state == DONE) begin
                range_q <= RANGE_WIDTH'(16'h8000);
                low_q   <= '0;
                cnt_q   <= -6'sd9;
            end
        end
    end

`ifdef RENORM_STATS_EN
    always_ff @(posedge clk) begin : stats_reg
        if (reset) begin
            stat_symbols <= '0;
            stat_words   <= '0;
        end else begin
            if (accept) stat_symbols <= stat_symbols + 32'd1;
            if (pop)    stat_words   <= stat_words + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_renorm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_renorm_ctrl
//
// Self-checking bench for renorm_ctrl: directed cases followed by randomized
// symbols, backpressure and flushes, compared against a behavioural model of
// the coder state and an expected-word queue.
// -----------------------------------------------------------------------------
module tb_renorm_ctrl;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush_req;
    logic [15:0]       range_q;
    logic [23:0]       low_q;
    logic signed [5:0] cnt_q;
    logic              flush_done;
    logic              err_zero_range;
`ifdef RENORM_STATS_EN
    logic [31:0]       stat_symbols;
    logic [31:0]       stat_words;
`endif

    renorm_ctrl_if bus ();

    renorm_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .flush_req      (flush_req),
        .range_q        (range_q),
        .low_q          (low_q),
        .cnt_q          (cnt_q),
        .flush_done     (flush_done),
        .err_zero_range (err_zero_range)
`ifdef RENORM_STATS_EN
        ,
        .stat_symbols   (stat_symbols),
        .stat_words     (stat_words)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model of the coder state
    int     m_range;
    longint m_low;
    int     m_cnt;
    int     exp_q[$];
    int     m_syms;
    int     m_words;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] cnt6(input int v);
        return v[5:0];
    endfunction

    function automatic int clz16(input int r);
        for (int b = 15; b >= 0; b--) begin
            if (r[b]) return 15 - b;
        end
        return 15;
    endfunction

    // Symbol rule: the number of completed words is 0, 1 or 2 depending on how
    // far cnt+d reaches; word k is taken from bit position cnt+16-8k.
    function automatic void model_symbol(input int rng, input longint lo);
        int d, s, n, sh;
        d = clz16(rng);
        s = m_cnt + d;
        n = (s < 0) ? 0 : ((s >= 8) ? 2 : 1);
        for (int k = 0; k < n; k++) begin
            sh = m_cnt + 16 - 8 * k;
            exp_q.push_back(int'((lo >> sh) & 64'hFFFF));
            lo = lo & ((64'd1 << sh) - 1);
        end
        m_low   = (lo << d) & 64'hFF_FFFF;
        m_range = (rng << d) & 32'hFFFF;
        m_cnt   = s - 8 * n;
        m_syms++;
    endfunction

    function automatic void model_flush();
        longint e;
        int s, n, sh;
        e = ((m_low + 64'h3FFF) & ~64'h3FFF) | 64'h4000;
        s = m_cnt + 10;
        n = (s > 8) ? 2 : ((s > 0) ? 1 : 0);
        for (int k = 0; k < n; k++) begin
            sh = m_cnt + 16 - 8 * k;
            exp_q.push_back(int'((e >> sh) & 64'hFFFF));
            e = e & ((64'd1 << sh) - 1);
        end
    endfunction

    function automatic void model_init();
        m_range = 32'h8000;
        m_low   = 0;
        m_cnt   = -9;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_range"}, 40'(range_q), 40'(m_range));
        check({tag, "_low"},   40'(low_q),   40'(m_low));
        check({tag, "_cnt"},   {34'd0, cnt_q}, {34'd0, cnt6(m_cnt)});
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.word_ready = 1'b0;
        flush_req      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_init();
        exp_q.delete();
        m_syms  = 0;
        m_words = 0;
    endtask

    // Called at a negedge with the controller idle.
    task automatic send(input string tag, input int rng, input int lo, input logic fr);
        check({tag, "_rdy"}, 40'(bus.in_ready), 40'd1);
        bus.in_valid = 1'b1;
        bus.in_range = rng[15:0];
        bus.in_low   = lo[23:0];
        flush_req    = fr;
        model_symbol(rng, longint'(lo[23:0]));
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush_req    = 1'b0;
        check_state(tag);
        check({tag, "_wvalid"}, 40'(bus.word_valid), 40'(exp_q.size() != 0));
    endtask

    // Pops every expected word with random backpressure; bounded by a cycle budget.
    task automatic drain(input string tag, input int stall_pct);
        int   guard;
        logic rdy, v;
        guard = 0;
        while (exp_q.size() > 0) begin
            if (guard >= 64) begin
                check({tag, "_timeout"}, 40'(guard), 40'd0);
                exp_q.delete();
                break;
            end
            check({tag, "_wvalid"}, 40'(bus.word_valid), 40'd1);
            check({tag, "_wdata"},  40'(bus.word_data),  40'(exp_q[0]));
            check({tag, "_busy"},   40'(bus.in_ready),   40'd0);
            rdy = ($urandom_range(0, 99) >= stall_pct);
            v   = bus.word_valid;
            bus.word_ready = rdy;
            @(negedge clk);
            if (rdy && v) begin
                void'(exp_q.pop_front());
                m_words++;
            end
            guard++;
        end
        bus.word_ready = 1'b0;
    endtask

    task automatic drain_symbol(input string tag, input int stall_pct);
        drain(tag, stall_pct);
        check({tag, "_idle"}, 40'(bus.in_ready), 40'd1);
        check({tag, "_wempty"}, 40'(bus.word_valid), 40'd0);
    endtask

    task automatic do_flush(input string tag, input int stall_pct);
        flush_req = 1'b1;
        model_flush();
        @(negedge clk);
        flush_req = 1'b0;
        drain(tag, stall_pct);
        check({tag, "_done"}, 40'(flush_done), 40'd1);
        check({tag, "_done_busy"}, 40'(bus.in_ready), 40'd0);
        @(negedge clk);
        check({tag, "_done_end"}, 40'(flush_done), 40'd0);
        check({tag, "_idle"}, 40'(bus.in_ready), 40'd1);
        model_init();
        check_state({tag, "_reinit"});
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_range   = '0;
        bus.in_low     = '0;
        bus.word_ready = 1'b0;
        flush_req      = 1'b0;
        reset          = 1'b1;

        // Reset state
        do_reset();
        check_state("reset");
        check("reset_wvalid", 40'(bus.word_valid), 40'd0);
        check("reset_wdata",  40'(bus.word_data),  40'd0);
        check("reset_rdy",    40'(bus.in_ready),   40'd1);
        check("reset_done",   40'(flush_done),     40'd0);
        check("reset_err",    40'(err_zero_range), 40'd0);

        // Normalization without word output
        send("t1a", 32'h0100, 32'h00ABCD, 1'b0);
        check("t1a_low_const", 40'(low_q), 40'h55E680);
        check("t1a_cnt_const", {34'd0, cnt_q}, {34'd0, cnt6(-2)});
        send("t1b", 32'h4000, 32'h55E680, 1'b0);
        check("t1b_low_const", 40'(low_q), 40'hABCD00);
        check("t1b_cnt_const", {34'd0, cnt_q}, {34'd0, cnt6(-1)});

        // Two words from cnt=-1
        send("t2", 32'h0001, 32'hABCD00, 1'b0);
        check("t2_w0_const", 40'(bus.word_data), 40'h0157);
        check("t2_range_const", 40'(range_q), 40'h8000);
        drain_symbol("t2", 0);

        // Same case held off by word_ready=0 for 5 cycles
        send("t3a", 32'h4000, 32'h000000, 1'b0);
        send("t3", 32'h0001, 32'hABCD00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_data", 40'(bus.word_data), 40'h0157);
            check("t3_hold_rdy",  40'(bus.in_ready),  40'd0);
            @(negedge clk);
        end
        drain_symbol("t3", 0);

        // Flush from low=0, cnt=-2: single word 0x0001
        check("t4_cnt_pre", {34'd0, cnt_q}, {34'd0, cnt6(-2)});
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        check("t4_word_const", 40'(bus.word_data), 40'h0001);
        model_flush();
        @(negedge clk);
        exp_q.delete();
        drain("t4", 0);
        check("t4_done", 40'(flush_done), 40'd0);
        // The word above is popped implicitly: drive ready for one cycle.
        bus.word_ready = 1'b1;
        @(negedge clk);
        bus.word_ready = 1'b0;
        check("t4_done_pulse", 40'(flush_done), 40'd1);
        @(negedge clk);
        check("t4_done_end", 40'(flush_done), 40'd0);
        model_init();
        check_state("t4_reinit");

        // Randomized symbols, backpressure and flushes
        for (int it = 0; it < 300; it++) begin
            int rng, lo;
            rng = $urandom_range(1, 65535) >> $urandom_range(0, 15);
            if (rng == 0) rng = 1;
            lo = int'($urandom & 32'hFF_FFFF);
            send("rnd", rng, lo, 1'b0);
            drain_symbol("rnd", 30);
            if ($urandom_range(0, 19) == 0) do_flush("rnd_fl", 30);
        end
        do_flush("rnd_fl_end", 50);

`ifdef RENORM_STATS_EN
        check("stat_symbols", 40'(stat_symbols), 40'(m_syms));
        check("stat_words",   40'(stat_words),   40'(m_words));
`endif

        // Reset with a word pending discards it
        send("mid", 32'h0001, 32'h123456, 1'b0);
        check("mid_pending", 40'(bus.word_valid), 40'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_wvalid", 40'(bus.word_valid), 40'd0);
        reset = 1'b0;
        model_init();
        exp_q.delete();
        m_syms  = 0;
        m_words = 0;
        check_state("mid_rst");
        check("mid_rst_rdy", 40'(bus.in_ready), 40'd1);

        // Symbol and flush_req together: symbol wins; zero range flags error
        send("t5", 32'h0000, 32'h000123, 1'b1);
        check("t5_word_const", 40'(bus.word_data), 40'h0002);
        check("t5_err", 40'(err_zero_range), 40'd1);
        check("t5_no_done", 40'(flush_done), 40'd0);
        drain_symbol("t5", 20);
        send("t6", 32'h1234, 32'h00ABCD, 1'b0);
        drain_symbol("t6", 20);
        do_flush("t6_fl", 20);
        check("t6_err_sticky", 40'(err_zero_range), 40'd1);

`ifdef RENORM_STATS_EN
        check("stat_symbols_end", 40'(stat_symbols), 40'(m_syms));
        check("stat_words_end",   40'(stat_words),   40'(m_words));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/renorm_ctrl.md
Name: renorm_ctrl

Overview:
- Sequential renormalization controller for the AV1 arithmetic encoder; sits after stage 2 in place of the combinational stage 3.
- Owns the encoder state: normalized range, low, and signed bit counter cnt.
- Normalizes each symbol result by the leading-zero count of range, extracts completed precarry words (up to two per symbol), and streams them out over valid/ready.
- Also sequences end-of-stream flush.

Parameters:
- RANGE_WIDTH, 16, range width
- LOW_WIDTH, 24, held low register width (internal shift datapath is LOW_WIDTH+16)
- D_SIZE, 5, shift-amount width
- WORD_WIDTH, 16, precarry word width (bit 8 = carry, bits 15:9 always 0)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  symbol result valid
- in_ready  out  1  controller can accept a symbol
- in_range  in  RANGE_WIDTH  unnormalized range from stage 2 (nonzero)
- in_low  in  LOW_WIDTH  unnormalized low from stage 2
- flush_req  in  1  level; start flush when idle
- range_q  out  RANGE_WIDTH  normalized range, fed back to stage 1
- low_q  out  LOW_WIDTH  normalized low, fed back to stage 2
- cnt_q  out  6  signed bit counter
- word_valid  out  1  precarry word valid
- word_ready  in  1  downstream accepts word
- word_data  out  WORD_WIDTH  precarry word
- flush_done  out  1  one-cycle pulse after last flush word accepted
- err_zero_range  out  1  sticky; set if an accepted in_range==0

Behaviour:
- Reset values: range_q=0x8000, low_q=0, cnt_q=-9, word_valid=0, word_data=0, flush_done=0, err_zero_range=0, state IDLE. Reset mid-operation discards pending words.
- States:
  - IDLE: in_ready=1.
  - EMIT: 1–2 words held in a 2-entry output buffer; in_ready=0.
  - FLUSH: flush words held; in_ready=0.
  - DONE: flush_done pulse, then IDLE.
- Symbol accept (in_valid & in_ready): all arithmetic below completes the same cycle; results are registered next edge (1-cycle latency to range_q/low_q/cnt_q).
  - d = leading zeros of in_range (0..15). in_range==0 sets err_zero_range and uses d=15.
  - s = cnt+d.
  - If s>=0:
    - c = cnt+16.
    - If s>=8: word1 = low>>c; low &= (1<<c)-1; c -= 8.
    - Next word = low>>c; low &= (1<<c)-1; s = c+d-24.
  - low <<= d; range <<= d; cnt = s.
  - Next state is EMIT if any word was produced, else IDLE.
- Emitted words appear in order; the first word is presented the cycle after accept.
- EMIT: a word pops on word_valid & word_ready. word_data/word_valid hold stable while word_ready=0. Return to IDLE the cycle after the last pop.
- Flush: taken only in IDLE with in_valid=0; in_valid has priority if both are asserted.
  - e = ((low+0x3FFF) & ~0x3FFF) | 0x4000; s = cnt+10; c = cnt.
  - While s>0: word = e>>(c+16); e &= (1<<(c+16))-1; s -= 8; c -= 8. At most 2 words.
  - After the last pop: DONE (flush_done=1 for one cycle), then reinit range_q/low_q/cnt_q to reset values and return to IDLE.
- Range invariant: range_q[15]=1 after every accept. The intermediate shift cannot overflow LOW_WIDTH+16 bits.

Optional Feature:
- Macro RENORM_STATS_EN.
- When defined: adds outputs stat_symbols (32b, accepted symbols) and stat_words (32b, popped words). Both counters wrap, are cleared by reset, and are held through flush.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset -> range_q=0x8000, low_q=0, cnt_q=-9, word_valid=0, in_ready=1.
- Accept in_range=0x0100, in_low=0x00ABCD -> range_q=0x8000, low_q=0x55E680, cnt_q=-2, no word. Then in_range=0x4000, in_low=0x55E680 -> low_q=0xABCD00, cnt_q=-1.
- From cnt=-1: in_range=0x0001, in_low=0xABCD00 -> words 0x0157 then 0x009A; range_q=0x8000, low_q=0, cnt_q=-2.
- Same case with word_ready=0 for 5 cycles -> word_data holds 0x0157, in_ready=0 throughout; both words are then popped in order.
- From low=0, cnt=-2: flush_req -> single word 0x0001, then flush_done pulse, then state reinitialized to reset values.
- in_valid and flush_req asserted together in IDLE -> symbol taken first; accept in_range=0 -> err_zero_range=1 and stays set.
